// File: rtl/nb_msg_bram_if.sv
// User-side port bundle of nb_msg_bram: enable, write/read strobes, clear request and read results.
// NB_MSG_BRAM_PARITY_EN adds the par_err result line.
interface nb_msg_bram_if #(
  parameter int DATA_W = 20,
  parameter int ADDR_W = 12
);
  logic              core_en;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] data_in;
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic              clear_req;
  logic [DATA_W-1:0] data_out;
  logic              rd_valid;
  logic              init_busy;
`ifdef NB_MSG_BRAM_PARITY_EN
  logic              par_err;
`endif

  modport master (
    output core_en, wr_en, wr_addr, data_in, rd_en, rd_addr, clear_req,
    input  data_out, rd_valid, init_busy
`ifdef NB_MSG_BRAM_PARITY_EN
    , input par_err
`endif
  );

  modport slave (
    input  core_en, wr_en, wr_addr, data_in, rd_en, rd_addr, clear_req,
    output data_out, rd_valid, init_busy
`ifdef NB_MSG_BRAM_PARITY_EN
    , output par_err
`endif
  );
endinterface

// File: rtl/nb_msg_bram.sv
// NB-LDPC message memory: independent read/write ports, write-first bypass, RD_LAT read pipeline
// and a self-clearing init sequencer. Define NB_MSG_BRAM_PARITY_EN to store and check even parity.
module nb_msg_bram #(
  parameter int                DATA_W   = 20,
  parameter int                ADDR_W   = 12,
  parameter int                DEPTH    = 4096,
  parameter int                RD_LAT   = 1,
  parameter logic [DATA_W-1:0] INIT_VAL = '0
) (
  input  logic         clk,
  input  logic         rst_n,
  nb_msg_bram_if.slave bus
);

`ifdef NB_MSG_BRAM_PARITY_EN
  localparam int MEM_W = DATA_W + 1;
`else
  localparam int MEM_W = DATA_W;
`endif
  localparam int                IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0]   DEPTH_C = (ADDR_W + 1)'(DEPTH);
  localparam logic [IDX_W-1:0]  LAST_C  = IDX_W'(DEPTH - 1);

  typedef enum logic {ST_CLEAR, ST_READY} state_t;

  function automatic logic [MEM_W-1:0] encode(input logic [DATA_W-1:0] d);
`ifdef NB_MSG_BRAM_PARITY_EN
    return {^d, d};
`else
    return d;
`endif
  endfunction

  logic [MEM_W-1:0]  mem [DEPTH];

  state_t            state_q;
  logic [IDX_W-1:0]  clr_cnt_q;
  logic              init_busy_q;

  logic              wr_go_d;
  logic [IDX_W-1:0]  wr_idx_d;
  logic [MEM_W-1:0]  wr_word_d;

  logic              rd_go_d;
  logic              rd_hit_d;
  logic              rd_byp_d;
  logic [MEM_W-1:0]  rd_word_d;
  logic [DATA_W-1:0] rd_data_p0_d;

  logic              vld_p1_q;
  logic [DATA_W-1:0] data_p1_q;

  // Sequencer: CLEAR sweeps every word once, READY serves the user port.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_CLEAR;
      clr_cnt_q   <= '0;
      init_busy_q <= 1'b1;
    end else if (bus.core_en) begin
      unique case (state_q)
        ST_CLEAR: begin
          if (clr_cnt_q == LAST_C) begin
            state_q     <= ST_READY;
            clr_cnt_q   <= '0;
            init_busy_q <= 1'b0;
          end else begin
            clr_cnt_q <= clr_cnt_q + 1'b1;
          end
        end
        ST_READY: begin
          if (bus.clear_req) begin
            state_q     <= ST_CLEAR;
            clr_cnt_q   <= '0;
            init_busy_q <= 1'b1;
          end
        end
        default: state_q <= ST_CLEAR;
      endcase
    end
  end

  // Single write port shared by the sequencer and the user; out-of-range writes are dropped.
  always_comb begin
    wr_go_d   = 1'b0;
    wr_idx_d  = '0;
    wr_word_d = '0;
    if (bus.core_en) begin
      if (state_q == ST_CLEAR) begin
        wr_go_d   = 1'b1;
        wr_idx_d  = clr_cnt_q;
        wr_word_d = encode(INIT_VAL);
      end else if (bus.wr_en && ({1'b0, bus.wr_addr} < DEPTH_C)) begin
        wr_go_d   = 1'b1;
        wr_idx_d  = bus.wr_addr[IDX_W-1:0];
        wr_word_d = encode(bus.data_in);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (wr_go_d) mem[wr_idx_d] <= wr_word_d;
  end

  // ---- stage p0: address decode, array read, write-first bypass ----
  assign rd_go_d   = bus.core_en && bus.rd_en && (state_q == ST_READY);
  assign rd_hit_d  = ({1'b0, bus.rd_addr} < DEPTH_C);
  assign rd_byp_d  = bus.wr_en && (bus.wr_addr == bus.rd_addr);
  assign rd_word_d = mem[bus.rd_addr[IDX_W-1:0]];

  always_comb begin
    rd_data_p0_d = '0;
    if (rd_hit_d) rd_data_p0_d = rd_byp_d ? bus.data_in : rd_word_d[DATA_W-1:0];
  end

  // ---- stage p1: first read register; data only moves on an accepted read ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1_q  <= 1'b0;
      data_p1_q <= '0;
    end else if (bus.core_en) begin
      vld_p1_q <= rd_go_d;
      if (rd_go_d) data_p1_q <= rd_data_p0_d;
    end
  end

`ifdef NB_MSG_BRAM_PARITY_EN
  logic perr_p1_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) perr_p1_q <= 1'b0;
    else if (bus.core_en) perr_p1_q <= rd_go_d && rd_hit_d && !rd_byp_d && (^rd_word_d);
  end
`endif

  assign bus.init_busy = init_busy_q;

  // ---- stage p2: optional extra output register ----
  if (RD_LAT >= 2) begin : g_lat2
    logic              vld_p2_q;
    logic [DATA_W-1:0] data_p2_q;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        vld_p2_q  <= 1'b0;
        data_p2_q <= '0;
      end else if (bus.core_en) begin
        vld_p2_q <= vld_p1_q;
        if (vld_p1_q) data_p2_q <= data_p1_q;
      end
    end

    assign bus.rd_valid = vld_p2_q;
    assign bus.data_out = data_p2_q;
`ifdef NB_MSG_BRAM_PARITY_EN
    logic perr_p2_q;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) perr_p2_q <= 1'b0;
      else if (bus.core_en) perr_p2_q <= perr_p1_q;
    end

    assign bus.par_err = perr_p2_q;
`endif
  end else begin : g_lat1
    assign bus.rd_valid = vld_p1_q;
    assign bus.data_out = data_p1_q;
`ifdef NB_MSG_BRAM_PARITY_EN
    assign bus.par_err  = perr_p1_q;
`endif
  end

endmodule
